// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external synchronous RAM; pointers, word count, sticky error flags and read-valid pipeline.
// Define RAM_FIFO_CTRL_OUTPUT_REG_EN when the RAM's registered output is enabled (2-cycle read latency).
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    input  logic                  rd_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   used_words_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  ram_wr_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic                  ram_rd_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    output logic                  ram_output_reg_en_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

`ifdef RAM_FIFO_CTRL_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [ADDR_WIDTH:0]   FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  ovf;
    logic                  unf;
    logic [LAT:1]          vld_pipe;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  full;
    logic                  empty;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    // Full rejects writes even when a read frees a slot in the same cycle.
    assign wr_acc = wr_i && !full;
    assign rd_acc = rd_i && !empty;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            vld_pipe <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_acc && !rd_acc)
                count <= count + CNT_ONE;
            else if (rd_acc && !wr_acc)
                count <= count - CNT_ONE;
            if (wr_i && !wr_acc)
                ovf <= 1'b1;
            if (rd_i && !rd_acc)
                unf <= 1'b1;
`ifdef RAM_FIFO_CTRL_OUTPUT_REG_EN
            vld_pipe <= {vld_pipe[1], rd_acc};
`else
            vld_pipe <= rd_acc;
`endif
        end
    end

    assign full_o        = full;
    assign empty_o       = empty;
    assign used_words_o  = count;
    assign overflow_o    = ovf;
    assign underflow_o   = unf;
    assign ram_wr_o      = wr_acc;
    assign ram_wr_addr_o = wr_ptr;
    assign ram_wr_data_o = wr_data_i;
    assign ram_rd_o      = rd_acc;
    assign ram_rd_addr_o = rd_ptr;
    assign rd_data_o     = ram_rd_data_i;
    assign rd_valid_o    = vld_pipe[LAT];

`ifdef RAM_FIFO_CTRL_OUTPUT_REG_EN
    // RAM output register loads while the raw read word sits on its array output.
    assign ram_output_reg_en_o = vld_pipe[1];
`else
    assign ram_output_reg_en_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl (depth 4): directed scenarios plus random traffic checked against a queue-based model.
module tb_ram_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef RAM_FIFO_CTRL_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          wr_i;
    logic [DW-1:0] wr_data_i;
    logic          full_o;
    logic          rd_i;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          empty_o;
    logic [AW:0]   used_words_o;
    logic          overflow_o;
    logic          underflow_o;
    logic          ram_wr_o;
    logic [AW-1:0] ram_wr_addr_o;
    logic [DW-1:0] ram_wr_data_o;
    logic          ram_rd_o;
    logic [AW-1:0] ram_rd_addr_o;
    logic          ram_output_reg_en_o;
    logic [DW-1:0] ram_rd_data_i;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .wr_i(wr_i), .wr_data_i(wr_data_i), .full_o(full_o),
        .rd_i(rd_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .empty_o(empty_o), .used_words_o(used_words_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o),
        .ram_wr_o(ram_wr_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
        .ram_rd_o(ram_rd_o), .ram_rd_addr_o(ram_rd_addr_o),
        .ram_output_reg_en_o(ram_output_reg_en_o), .ram_rd_data_i(ram_rd_data_i)
    );

    // External synchronous RAM, optional output register
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q1, q2;
    always @(posedge clk) begin
        if (ram_wr_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
        if (ram_rd_o) q1 <= mem[ram_rd_addr_o];
        if (ram_output_reg_en_o) q2 <= q1;
    end
`ifdef RAM_FIFO_CTRL_OUTPUT_REG_EN
    assign ram_rd_data_i = q2;
`else
    assign ram_rd_data_i = q1;
`endif

    typedef struct { int due; logic [DW-1:0] d; } pend_t;
    logic [DW-1:0] fifo_q [$];
    pend_t         pend [$];
    int  cyc = 0, wcnt = 0, rcnt = 0;
    bit  ovf = 0, unf = 0;
    int  checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete(); pend.delete();
        wcnt = 0; rcnt = 0; ovf = 0; unf = 0;
    endtask

    // Registered-state checks, sampled just after the clock edge
    task automatic post_check();
        bit ev;
        check("used_words", used_words_o, fifo_q.size());
        check("empty", empty_o, fifo_q.size() == 0);
        check("full", full_o, fifo_q.size() == DEPTH);
        check("overflow", overflow_o, ovf);
        check("underflow", underflow_o, unf);
        ev = pend.size() > 0 && pend[0].due == cyc;
        check("rd_valid", rd_valid_o, ev);
        if (ev) begin
            check("rd_data", rd_data_o, pend[0].d);
            void'(pend.pop_front());
        end
`ifdef RAM_FIFO_CTRL_OUTPUT_REG_EN
        check("oreg_en", ram_output_reg_en_o, pend.size() > 0 && pend[0].due == cyc + 1);
`else
        check("oreg_en", ram_output_reg_en_o, 0);
`endif
    endtask

    task automatic step(input bit w, input logic [DW-1:0] wd, input bit r);
        bit wa, ra;
        @(negedge clk);
        wr_i = w; wr_data_i = wd; rd_i = r;
        #1;
        wa = w && fifo_q.size() < DEPTH;
        ra = r && fifo_q.size() > 0;
        check("ram_wr", ram_wr_o, wa);
        check("ram_rd", ram_rd_o, ra);
        if (wa) begin
            check("wr_addr", ram_wr_addr_o, wcnt % DEPTH);
            check("wr_data", ram_wr_data_o, wd);
        end
        if (ra) begin
            check("rd_addr", ram_rd_addr_o, rcnt % DEPTH);
            pend.push_back('{cyc + LAT, fifo_q.pop_front()});
            rcnt++;
        end
        if (wa) begin
            fifo_q.push_back(wd);
            wcnt++;
        end
        if (w && !wa) ovf = 1;
        if (r && !ra) unf = 1;
        @(posedge clk);
        cyc++;
        #1;
        post_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0);
    endtask

    initial begin
        logic [DW-1:0] seq [4];
        int peak;
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        rst_n_i = 1'b0; wr_i = 0; rd_i = 0; wr_data_i = '0;
        #12;
        model_reset();
        post_check();
        @(negedge clk);
        rst_n_i = 1'b1;

        // Fill to full, then drain in order
        for (int i = 0; i < 4; i++) step(1, seq[i], 0);
        check("full_after_4", full_o, 1);
        for (int i = 0; i < 4; i++) step(0, '0, 1);
        idle(LAT);
        check("empty_after_drain", empty_o, 1);

        // Write and read together while full: read wins, write dropped
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0);
        step(1, 8'h55, 1);
        check("ovf_set", overflow_o, 1);
        check("used_after_ovf", used_words_o, 3);
        check("not_full", full_o, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1);
        idle(LAT);

        // Read and write together while empty: write wins, no fall-through
        step(1, 8'h66, 1);
        check("ram_rd_never_on_empty", underflow_o, 1);
        step(0, '0, 1);
        idle(LAT);
        step(0, '0, 1);
        idle(2);

        // Interleaved pairs, pointers wrap
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(8'h70 + i), 0);
            if (used_words_o > peak) peak = used_words_o;
            step(0, '0, 1);
        end
        idle(LAT);
        check("peak_le_depth", peak <= DEPTH, 1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);
        idle(LAT + 1);

        // Async reset during a read burst
        for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0);
        step(0, '0, 1);
        step(0, '0, 1);
        #2;
        rst_n_i = 1'b0; wr_i = 0; rd_i = 0;
        #1;
        model_reset();
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_used", used_words_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_unf", underflow_o, 0);
        check("rst_oreg", ram_output_reg_en_o, 0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n_i = 1'b1;
        idle(3);
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1);
        idle(LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
